// File: rtl/mem_resp_pkg.sv
// Shared widths, base address and handshake FSM states for the memory responder.
package mem_resp_pkg;

    localparam int          CPU_WIDTH     = 32;
    localparam int          MASK_WIDTH    = 4;
    localparam logic [31:0] MEM_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } memState_t;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module mem_ram
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_wen,
    input  logic [AW-1:0]         i_idx,
    input  logic [CPU_WIDTH-1:0]  i_wdata,
    input  logic [MASK_WIDTH-1:0] i_wmask,
    output logic [CPU_WIDTH-1:0]  o_rdata
);

    logic [CPU_WIDTH-1:0] memArray [DEPTH];

    // Read data only updates on a read, so it holds steady while a response is stalled.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_wen) begin
                for (int b = 0; b < MASK_WIDTH; b++) begin
                    if (i_wmask[b]) begin
                        memArray[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                o_rdata <= memArray[i_idx];
            end
        end
    end

endmodule

// File: rtl/mem_resp.sv
// Memory responder: valid/ready request and response channels in front of a word RAM
// with a programmable number of wait cycles between accept and response.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = MEM_BASE_ADDR,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [CPU_WIDTH-1:0]  i_req_addr,
    input  logic [CPU_WIDTH-1:0]  i_req_wdata,
    input  logic [MASK_WIDTH-1:0] i_req_wmask,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [CPU_WIDTH-1:0]  o_rsp_rdata,
    output logic                  o_rsp_err
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    localparam logic [31:0] LAT  = 32'(LATENCY);

    memState_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;

    logic                  wen_q;
    logic [CPU_WIDTH-1:0]  addr_q;
    logic [CPU_WIDTH-1:0]  wdata_q;
    logic [MASK_WIDTH-1:0] wmask_q;
    logic                  err_q;
    logic                  rdOk_q;

    logic                  latchReq;
    logic                  commit;
    logic                  useInputs;
    logic                  cWen;
    logic [CPU_WIDTH-1:0]  cAddr;
    logic [CPU_WIDTH-1:0]  cWdata;
    logic [MASK_WIDTH-1:0] cWmask;
    logic [CPU_WIDTH-1:0]  offset;
    logic                  inRange;
    logic                  ramEn;
    logic [CPU_WIDTH-1:0]  ramRdata;

    // With zero latency the commit happens on the accept edge, straight from the request inputs.
    assign useInputs = (state_q == MEM_IDLE);

    always_comb begin
        cWen    = useInputs ? i_req_wen   : wen_q;
        cAddr   = useInputs ? i_req_addr  : addr_q;
        cWdata  = useInputs ? i_req_wdata : wdata_q;
        cWmask  = useInputs ? i_req_wmask : wmask_q;
        offset  = cAddr - BASE_ADDR;
        inRange = (cAddr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latchReq = 1'b0;
        commit   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (i_req_valid) begin
                    latchReq = 1'b1;
                    if (LATENCY == 0) begin
                        commit  = 1'b1;
                        state_d = MEM_RESP;
                    end else begin
                        cnt_d   = LAT;
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q <= 32'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 32'd0;
                    state_d = MEM_RESP;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            MEM_RESP: begin
                if (i_rsp_ready) begin
                    state_d = MEM_IDLE;
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
            rdOk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                err_q  <= !inRange;
                rdOk_q <= inRange && !cWen;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (latchReq) begin
            wen_q   <= i_req_wen;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            wmask_q <= i_req_wmask;
        end
    end

    // A reset landing on the commit edge drops the pending write.
    assign ramEn = commit && inRange && !i_rst;

    mem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (ramEn),
        .i_wen   (cWen),
        .i_idx   (offset[AW+1:2]),
        .i_wdata (cWdata),
        .i_wmask (cWmask),
        .o_rdata (ramRdata)
    );

    assign o_req_ready = (state_q == MEM_IDLE);
    assign o_rsp_valid = (state_q == MEM_RESP);
    assign o_rsp_err   = (state_q == MEM_RESP) && err_q;
    assign o_rsp_rdata = ((state_q == MEM_RESP) && rdOk_q) ? ramRdata : '0;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench: two responders (latency 2 and 0) driven from vector tables,
// hand-written corner sequences and random traffic checked against a word-array model.
module tb_mem_resp;

    logic        clk;
    logic        rst;
    logic [1:0]  reqValid;
    logic        reqWen;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [3:0]  reqWmask;
    logic        rspReady;
    logic [1:0]  reqReady;
    logic [1:0]  rspValid;
    logic [31:0] rspRdata [2];
    logic [1:0]  rspErr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] modelMem [2][1024];

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          stall;
        logic [31:0] expRdata;
        bit          expErr;
    } vec_t;

    vec_t vecs[$];

    mem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (reqValid[0]),
        .o_req_ready (reqReady[0]),
        .i_req_wen   (reqWen),
        .i_req_addr  (reqAddr),
        .i_req_wdata (reqWdata),
        .i_req_wmask (reqWmask),
        .o_rsp_valid (rspValid[0]),
        .i_rsp_ready (rspReady),
        .o_rsp_rdata (rspRdata[0]),
        .o_rsp_err   (rspErr[0])
    );

    mem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(0)) dut0 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (reqValid[1]),
        .o_req_ready (reqReady[1]),
        .i_req_wen   (reqWen),
        .i_req_addr  (reqAddr),
        .i_req_wdata (reqWdata),
        .i_req_wmask (reqWmask),
        .o_rsp_valid (rspValid[1]),
        .i_rsp_ready (rspReady),
        .o_rsp_rdata (rspRdata[1]),
        .o_rsp_err   (rspErr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory as a flat array of words; answers from address arithmetic alone.
    task automatic modelApply(input int sel, input bit wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wmask,
                              output logic [31:0] expRdata, output bit expErr);
        longint off;
        int     idx;
        off = longint'(addr) - longint'(32'h8000_0000);
        if (off < 0 || off >= 4 * 1024) begin
            expErr   = 1'b1;
            expRdata = 32'h0;
        end else begin
            idx    = int'(off / 4);
            expErr = 1'b0;
            if (wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) modelMem[sel][idx][8*b +: 8] = wdata[8*b +: 8];
                end
                expRdata = 32'h0;
            end else begin
                expRdata = modelMem[sel][idx];
            end
        end
    endtask

    task automatic applyStimulus(input int sel, input bit wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wmask,
                                 input int stall, output logic [31:0] rdata, output logic err);
        int lat;
        int expLat;
        expLat        = (sel == 0) ? 2 : 0;
        reqWen        = wen;
        reqAddr       = addr;
        reqWdata      = wdata;
        reqWmask      = wmask;
        reqValid[sel] = 1'b1;
        checkOutput("req_ready_idle", 32'(reqReady[sel]), 32'd1);
        @(posedge clk);
        #1;
        reqValid[sel] = 1'b0;
        lat = 0;
        while (!rspValid[sel] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("resp_req_ready", 32'(reqReady[sel]), 32'd0);
        rdata = rspRdata[sel];
        err   = rspErr[sel];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", 32'(rspValid[sel]), 32'd1);
            checkOutput("bp_rdata", rspRdata[sel], rdata);
            checkOutput("bp_err", 32'(rspErr[sel]), 32'(err));
            checkOutput("bp_req_ready", 32'(reqReady[sel]), 32'd0);
        end
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        checkOutput("valid_drop", 32'(rspValid[sel]), 32'd0);
        checkOutput("ready_back", 32'(reqReady[sel]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] mr;
        bit          me;
        logic [31:0] oob [4];
        int          sel;
        logic [31:0] addr;

        rst      = 1'b1;
        reqValid = 2'b00;
        reqWen   = 1'b0;
        reqAddr  = 32'h0;
        reqWdata = 32'h0;
        reqWmask = 4'h0;
        rspReady = 1'b0;
        oob[0] = 32'h7FFF_FFFC;
        oob[1] = 32'h8000_1000;
        oob[2] = 32'hFFFF_FFFC;
        oob[3] = 32'h0000_0000;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput("rst_req_ready", 32'(reqReady[s]), 32'd1);
            checkOutput("rst_rsp_valid", 32'(rspValid[s]), 32'd0);
            checkOutput("rst_rdata", rspRdata[s], 32'h0);
            checkOutput("rst_err", 32'(rspErr[s]), 32'd0);
        end

        vecs.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 1, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDE22_BE44, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 2, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h8000_0010, 32'h0,         4'h0, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0, 5, 32'hDE22_BE44, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_0FFF, 32'h1234_5678, 4'hF, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 0, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_0020, 32'h0BAD_C0DE, 4'hF, 0, 32'h0,         1'b0});

        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                          vecs[i].stall, rd, er);
            modelApply(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, mr, me);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].expErr));
        end

        // Reset while a write sits in WAIT: the write must never land.
        reqWen        = 1'b1;
        reqAddr       = 32'h8000_0020;
        reqWdata      = 32'hAAAA_AAAA;
        reqWmask      = 4'hF;
        reqValid[0]   = 1'b1;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        checkOutput("wait_req_ready", 32'(reqReady[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_req_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("midrst_rsp_valid", 32'(rspValid[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_idle_valid", 32'(rspValid[0]), 32'd0);
        applyStimulus(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er);
        checkOutput("midrst_read", rd, 32'h0BAD_C0DE);

        // Zero-latency responder.
        applyStimulus(1, 1'b1, 32'h8000_0040, 32'h55AA_55AA, 4'hF, 0, rd, er);
        modelApply(1, 1'b1, 32'h8000_0040, 32'h55AA_55AA, 4'hF, mr, me);
        checkOutput("lat0_wr_err", 32'(er), 32'd0);
        applyStimulus(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 2, rd, er);
        checkOutput("lat0_rd_data", rd, 32'h55AA_55AA);

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                addr = 32'h8000_0100 + 32'(4 * w);
                reqWdata = $urandom;
                modelApply(s, 1'b1, addr, reqWdata, 4'hF, mr, me);
                applyStimulus(s, 1'b1, addr, reqWdata, 4'hF, 0, rd, er);
                checkOutput("prefill_err", 32'(er), 32'(me));
            end
        end

        for (int n = 0; n < 80; n++) begin
            logic        wen;
            logic [31:0] wdata;
            logic [3:0]  wmask;
            sel = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                addr = 32'h8000_0100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            end else begin
                addr = oob[$urandom_range(0, 3)];
            end
            wen   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            wmask = 4'($urandom_range(0, 15));
            modelApply(sel, wen, addr, wdata, wmask, mr, me);
            applyStimulus(sel, wen, addr, wdata, wmask, int'($urandom_range(0, 2)), rd, er);
            checkOutput($sformatf("rand%0d_rdata", n), rd, mr);
            checkOutput($sformatf("rand%0d_err", n), 32'(er), 32'(me));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
